// File: rtl/gf180mcu_scan_chain_ctrl.sv
// Scan chain test sequencer: shift a pattern in, capture, shift the response out, compare.
// Optional macro SCAN_CTRL_RESP_EN adds the RESP output holding the last unloaded response.
module gf180mcu_scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN  = 32,
  parameter int unsigned CAP_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic [CHAIN_LEN-1:0] EXP,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
`ifdef SCAN_CTRL_RESP_EN
  output logic                 PASS,
  output logic [CHAIN_LEN-1:0] RESP
`else
  output logic                 PASS
`endif
);

  localparam int unsigned MAX_LEN = (CHAIN_LEN > CAP_CYCLES) ? CHAIN_LEN : CAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] CntShift = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CntCap   = CNT_W'(CAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StShiftIn  = 3'd1;
  localparam logic [2:0] StCapture  = 3'd2;
  localparam logic [2:0] StShiftOut = 3'd3;
  localparam logic [2:0] StCmp      = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    exp_d   = exp_q;
    resp_d  = resp_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          pat_d   = PAT;
          exp_d   = EXP;
          cnt_d   = CntShift;
          pass_d  = 1'b0;
          state_d = StShiftIn;
        end
      end
      StShiftIn: begin
        // Rotate rather than shift so every pattern bit stays live; MSB leaves first.
        pat_d = {pat_q[CHAIN_LEN-2:0], pat_q[CHAIN_LEN-1]};
        if (cnt_q == '0) begin
          cnt_d   = CntCap;
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StCapture: begin
        if (cnt_q == '0) begin
          cnt_d   = CntShift;
          state_d = StShiftOut;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StShiftOut: begin
        resp_d = {resp_q[CHAIN_LEN-2:0], SO};
        if (cnt_q == '0) begin
          state_d = StCmp;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StCmp: begin
        pass_d  = (resp_q == exp_q);
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    se_d   = (state_d == StShiftIn) || (state_d == StShiftOut);
    busy_d = (state_d == StShiftIn) || (state_d == StCapture) || (state_d == StShiftOut);
    si_d   = (state_d == StShiftIn) && pat_d[CHAIN_LEN-1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pat_q   <= '0;
      exp_q   <= '0;
      resp_q  <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      exp_q   <= exp_d;
      resp_q  <= resp_d;
      se_q    <= se_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign SE   = se_q;
  assign SI   = si_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign PASS = pass_q;

`ifdef SCAN_CTRL_RESP_EN
  logic [CHAIN_LEN-1:0] resp_out_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      resp_out_q <= '0;
    end else if (state_q == StCmp) begin
      resp_out_q <= resp_q;
    end
  end

  assign RESP = resp_out_q;
`endif

endmodule

// File: tb/tb_gf180mcu_scan_chain_ctrl.sv
// Self-checking bench: two sequencers (capture length 1 and 3) each driving a behavioural chain.
module tb_gf180mcu_scan_chain_ctrl;
  localparam int CL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic [CL-1:0] pat_a = '0, exp_a = '0, pat_b = '0, exp_b = '0;
  logic          so_a, se_a, si_a, busy_a, done_a, pass_a;
  logic          so_b, se_b, si_b, busy_b, done_b, pass_b;
`ifdef SCAN_CTRL_RESP_EN
  logic [CL-1:0] resp_a, resp_b;
`endif

  gf180mcu_scan_chain_ctrl #(.CHAIN_LEN(CL), .CAP_CYCLES(1)) dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .PAT(pat_a), .EXP(exp_a), .SO(so_a),
    .SE(se_a), .SI(si_a), .BUSY(busy_a), .DONE(done_a),
`ifdef SCAN_CTRL_RESP_EN
    .PASS(pass_a), .RESP(resp_a)
`else
    .PASS(pass_a)
`endif
  );

  gf180mcu_scan_chain_ctrl #(.CHAIN_LEN(CL), .CAP_CYCLES(3)) dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .PAT(pat_b), .EXP(exp_b), .SO(so_b),
    .SE(se_b), .SI(si_b), .BUSY(busy_b), .DONE(done_b),
`ifdef SCAN_CTRL_RESP_EN
    .PASS(pass_b), .RESP(resp_b)
`else
    .PASS(pass_b)
`endif
  );

  // Behavioural chains: A captures ~Q, B captures all ones.
  logic [CL-1:0] chain_a = '0, chain_b = '0;
  always @(posedge clk) begin
    if (se_a) chain_a <= {chain_a[CL-2:0], si_a};
    else      chain_a <= ~chain_a;
    if (se_b) chain_b <= {chain_b[CL-2:0], si_b};
    else      chain_b <= '1;
  end
  assign so_a = chain_a[CL-1];
  assign so_b = chain_b[CL-1];

  int n_checks = 0;
  int n_fail = 0;

  // Scoreboard queues: pushed at START, popped when the DUT reports DONE.
  bit            si_exp_q[$];
  bit            pass_exp_q[$];
  logic [CL-1:0] resp_exp_q[$];
  int            done_exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_checks++;
    if ({se_a, si_a, busy_a, done_a, pass_a} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_a: got %b required 00000", {se_a, si_a, busy_a, done_a, pass_a});
    end
    n_checks++;
    if ({se_b, si_b, busy_b, done_b, pass_b} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_b: got %b required 00000", {se_b, si_b, busy_b, done_b, pass_b});
    end
`ifdef SCAN_CTRL_RESP_EN
    n_checks++;
    if (resp_a !== '0) begin
      n_fail++;
      $display("FAIL reset_resp: got %h required 00", resp_a);
    end
`endif
  endtask

  // One run on chain A; optionally clobber PAT/EXP right after acceptance.
  task automatic test_run(input logic [CL-1:0] pat, input logic [CL-1:0] expv,
                          input bit clobber, input string name);
    int  busy_cnt = 0;
    bit  got_done = 0;
    int  cyc = 0;
    bit  e_si, e_pass;
    int  e_done;
    logic [CL-1:0] e_resp;
    for (int i = CL - 1; i >= 0; i--) si_exp_q.push_back(pat[i]);
    resp_exp_q.push_back(~pat);
    pass_exp_q.push_back((~pat) == expv);
    done_exp_q.push_back(2 * CL + 1 + 1);
    pat_a = pat;
    exp_a = expv;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    if (clobber) begin
      pat_a = '0;
      exp_a = '0;
    end
    while (!got_done && cyc < 40) begin
      if (cyc < CL) begin
        e_si = si_exp_q.pop_front();
        n_checks++;
        if ({se_a, si_a} !== {1'b1, e_si}) begin
          n_fail++;
          $display("FAIL %s si[%0d]: got se,si=%b%b required 1%b", name, cyc, se_a, si_a, e_si);
        end
      end
      if (busy_a === 1'b1) busy_cnt++;
      if (done_a === 1'b1) begin
        got_done = 1;
        e_done = done_exp_q.pop_front();
        e_pass = pass_exp_q.pop_front();
        e_resp = resp_exp_q.pop_front();
        n_checks++;
        if (cyc != e_done) begin
          n_fail++;
          $display("FAIL %s done_cycle: got %0d required %0d", name, cyc, e_done);
        end
        n_checks++;
        if (pass_a !== e_pass) begin
          n_fail++;
          $display("FAIL %s pass: got %b required %b", name, pass_a, e_pass);
        end
        n_checks++;
        if (busy_cnt != 2 * CL + 1) begin
          n_fail++;
          $display("FAIL %s busy_len: got %0d required %0d", name, busy_cnt, 2 * CL + 1);
        end
`ifdef SCAN_CTRL_RESP_EN
        n_checks++;
        if (resp_a !== e_resp) begin
          n_fail++;
          $display("FAIL %s resp: got %h required %h", name, resp_a, e_resp);
        end
`endif
      end else begin
        tick();
        cyc++;
      end
    end
    if (!got_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got no DONE required DONE", name);
      void'(done_exp_q.pop_front());
      void'(pass_exp_q.pop_front());
      void'(resp_exp_q.pop_front());
    end
    si_exp_q.delete();
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    int dcyc = -1;
    int cyc;
    pat_a = 8'hA5;
    exp_a = 8'h5A;
    start_a = 1'b1;
    tick();
    for (int c = 0; c < 45; c++) begin
      if (done_a === 1'b1) begin
        ndone++;
        dcyc = c;
      end
      start_a = (c == 3 || c == 10);
      tick();
    end
    start_a = 1'b0;
    n_checks++;
    if (ndone != 1 || dcyc != 18) begin
      n_fail++;
      $display("FAIL ignore_start: got %0d DONE at %0d required 1 DONE at 18", ndone, dcyc);
    end
    // START held high across a whole run and the DONE cycle.
    start_a = 1'b1;
    tick();
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 18) begin
      n_fail++;
      $display("FAIL held_done: got cycle %0d required 18", cyc);
    end
    tick();
    start_a = 1'b0;
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL held_restart: got busy=%b required 1", busy_a);
    end
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 18 || pass_a !== 1'b1) begin
      n_fail++;
      $display("FAIL held_second: got cycle %0d pass %b required cycle 18 pass 1", cyc, pass_a);
    end
    tick();
  endtask

  task automatic test_abort();
    int ndone = 0;
    pat_a = 8'hA5;
    exp_a = 8'h5A;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({se_a, busy_a, pass_a, done_a} !== 4'b0) begin
      n_fail++;
      $display("FAIL abort: got se,busy,pass,done=%b required 0000",
               {se_a, busy_a, pass_a, done_a});
    end
    for (int c = 0; c < 30; c++) begin
      if (done_a === 1'b1) ndone++;
      tick();
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL abort_done: got %0d DONE required 0", ndone);
    end
    test_run(8'hA5, 8'h5A, 1'b0, "after_abort");
  endtask

  task automatic test_capture3();
    int  cyc = 0;
    int  se_low = 0;
    bit  got_done = 0;
    int  e_done;
    bit  e_pass;
    logic [CL-1:0] e_resp;
    done_exp_q.push_back(2 * CL + 3 + 1);
    pass_exp_q.push_back(1'b1);
    resp_exp_q.push_back(8'hFF);
    pat_b = 8'h3C;
    exp_b = 8'hFF;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    while (!got_done && cyc < 50) begin
      if (busy_b === 1'b1 && se_b === 1'b0) se_low++;
      if (done_b === 1'b1) begin
        got_done = 1;
        e_done = done_exp_q.pop_front();
        e_pass = pass_exp_q.pop_front();
        e_resp = resp_exp_q.pop_front();
        n_checks++;
        if (cyc != e_done) begin
          n_fail++;
          $display("FAIL cap3 done_cycle: got %0d required %0d", cyc, e_done);
        end
        n_checks++;
        if (se_low != 3) begin
          n_fail++;
          $display("FAIL cap3 se_low: got %0d required 3", se_low);
        end
        n_checks++;
        if (pass_b !== e_pass) begin
          n_fail++;
          $display("FAIL cap3 pass: got %b required %b", pass_b, e_pass);
        end
`ifdef SCAN_CTRL_RESP_EN
        n_checks++;
        if (resp_b !== e_resp) begin
          n_fail++;
          $display("FAIL cap3 resp: got %h required %h", resp_b, e_resp);
        end
`endif
      end else begin
        tick();
        cyc++;
      end
    end
    if (!got_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL cap3 timeout: got no DONE required DONE");
    end
  endtask

  initial begin
    test_reset();
    test_run(8'hA5, 8'h5A, 1'b0, "basic");
    test_run(8'hA5, 8'h5B, 1'b0, "mismatch");
    test_run(8'h3C, 8'hC3, 1'b0, "pat3c");
    test_run(8'h00, 8'hFF, 1'b0, "zeros");
    test_run(8'h81, 8'h7F, 1'b0, "mism81");
    test_ignore_start();
    test_abort();
    test_capture3();
    test_run(8'hA5, 8'h5A, 1'b1, "clobber");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
